// File: rtl/gray_step_monitor_pkg.sv
// Shared types and helpers for the Gray step monitor: FSM states, 7-segment patterns, Gray decode.
package gray_mon_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic logic [6:0] seg7_pattern(input logic [2:0] v);
    logic [6:0] p;
    case (v)
      3'd0:    p = SEG_0;
      3'd1:    p = SEG_1;
      3'd2:    p = SEG_2;
      3'd3:    p = SEG_3;
      3'd4:    p = SEG_4;
      3'd5:    p = SEG_5;
      3'd6:    p = SEG_6;
      default: p = SEG_7;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/gray_step_monitor_if.sv
// Gray input and decoded/step outputs of the monitor; seg_n exists only with GRAY_MON_SEG7_EN.
interface gray_step_monitor_if;
  logic [2:0] gray_in;
  logic [2:0] bin_out;
  logic       step_valid;
  logic       dir_up;
  logic [7:0] position;
  logic       err_flag;
`ifdef GRAY_MON_SEG7_EN
  logic [6:0] seg_n;

  modport master (output gray_in,
                  input  bin_out, step_valid, dir_up, position, err_flag, seg_n);
  modport slave  (input  gray_in,
                  output bin_out, step_valid, dir_up, position, err_flag, seg_n);
`else
  modport master (output gray_in,
                  input  bin_out, step_valid, dir_up, position, err_flag);
  modport slave  (input  gray_in,
                  output bin_out, step_valid, dir_up, position, err_flag);
`endif
endinterface

// File: rtl/gray_sync2.sv
// 3-bit two-flop synchronizer for the asynchronous Gray word; 2-cycle latency, no backpressure.
module gray_sync2 (
  input  logic       clk,
  input  logic       async_reset,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      s1_q <= 3'b000;
      s2_q <= 3'b000;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/gray_step_monitor.sv
// Classifies Gray-code changes as up/down steps or illegal jumps; outputs move 3 edges after input, no backpressure.
// Optional registered 7-segment digit when GRAY_MON_SEG7_EN is defined.
module gray_step_monitor
  import gray_mon_pkg::*;
(
  input  logic               clk,
  input  logic               async_reset,
  input  logic               sync_clear,
  gray_step_monitor_if.slave mon
);

  logic [2:0] g_s;
  logic [2:0] b;

  gray_sync2 u_sync (
    .clk         (clk),
    .async_reset (async_reset),
    .d           (mon.gray_in),
    .q           (g_s)
  );

  assign b = gray2bin(g_s);

  state_t     state_q, state_d;
  logic [2:0] prev_b_q, prev_b_d;
  logic [2:0] bin_out_q, bin_out_d;
  logic       step_valid_q, step_valid_d;
  logic       dir_up_q, dir_up_d;
  logic [7:0] position_q, position_d;
  logic       err_flag_q, err_flag_d;
  logic [2:0] up_b, dn_b;

  always_comb begin
    state_d      = state_q;
    prev_b_d     = prev_b_q;
    bin_out_d    = bin_out_q;
    step_valid_d = 1'b0;
    dir_up_d     = dir_up_q;
    position_d   = position_q;
    err_flag_d   = err_flag_q;
    up_b         = prev_b_q + 3'd1;
    dn_b         = prev_b_q - 3'd1;

    // A clear discards any step seen in the same cycle; INIT re-seeds prev_b next edge
    if (sync_clear) begin
      state_d    = INIT;
      position_d = 8'h00;
      err_flag_d = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          prev_b_d  = b;
          bin_out_d = b;
          state_d   = TRACK;
        end
        TRACK: begin
          if (b != prev_b_q) begin
            prev_b_d  = b;
            bin_out_d = b;
            if (b == up_b) begin
              step_valid_d = 1'b1;
              dir_up_d     = 1'b1;
              position_d   = position_q + 8'd1;
            end else if (b == dn_b) begin
              step_valid_d = 1'b1;
              dir_up_d     = 1'b0;
              position_d   = position_q - 8'd1;
            end else begin
              err_flag_d = 1'b1;
              state_d    = FAULT;
            end
          end
        end
        FAULT: begin
          prev_b_d  = b;
          bin_out_d = b;
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q      <= INIT;
      prev_b_q     <= 3'b000;
      bin_out_q    <= 3'b000;
      step_valid_q <= 1'b0;
      dir_up_q     <= 1'b1;
      position_q   <= 8'h00;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_b_q     <= prev_b_d;
      bin_out_q    <= bin_out_d;
      step_valid_q <= step_valid_d;
      dir_up_q     <= dir_up_d;
      position_q   <= position_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign mon.bin_out    = bin_out_q;
  assign mon.step_valid = step_valid_q;
  assign mon.dir_up     = dir_up_q;
  assign mon.position   = position_q;
  assign mon.err_flag   = err_flag_q;

`ifdef GRAY_MON_SEG7_EN
  logic [6:0] seg_q, seg_d;

  // Decoded from bin_out_d so the digit changes on the same edge as bin_out
  always_comb begin
    seg_d = seg7_pattern(bin_out_d);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) seg_q <= SEG_0;
    else             seg_q <= seg_d;
  end

  assign mon.seg_n = seg_q;
`endif

endmodule
